// File: rtl/mips_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM states, default width.
// Divide support is compiled in only when MULTDIV_DIV_EN is defined.
package mips_pkg;

    localparam int unsigned MD_WIDTH = 32;

    typedef enum logic [2:0] {
        OpMult  = 3'b000,
        OpMultu = 3'b001,
        OpDiv   = 3'b010,
        OpDivu  = 3'b011,
        OpMthi  = 3'b100,
        OpMtlo  = 3'b101,
        OpNop0  = 3'b110,
        OpNop1  = 3'b111
    } md_op_t;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StCalc = 1'b1
    } md_state_t;

endpackage

// File: rtl/md_iter_core.sv
// One shift-add (multiply) or restoring-subtract (divide) step per cycle on magnitudes.
// The divide step exists only when MULTDIV_DIV_EN is defined.
module md_iter_core
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a_mag,
    input  logic [WIDTH-1:0] b_mag,
    output logic [WIDTH-1:0] nxt_hi,
    output logic [WIDTH-1:0] nxt_lo
);

    // Multiply: {acc_hi, acc_lo} = partial product / multiplier. Divide: remainder / quotient.
    logic [WIDTH-1:0] acc_hi_q, acc_lo_q, opnd_q;
    logic [WIDTH:0]   sum;

`ifdef MULTDIV_DIV_EN
    logic [WIDTH:0] shifted, diff;
`else
    logic unused_is_div;
    assign unused_is_div = is_div;
`endif

    always_comb begin
        sum    = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
        nxt_hi = sum[WIDTH:1];
        nxt_lo = {sum[0], acc_lo_q[WIDTH-1:1]};
`ifdef MULTDIV_DIV_EN
        shifted = {acc_hi_q, acc_lo_q[WIDTH-1]};
        diff    = shifted - {1'b0, opnd_q};
        if (is_div) begin
            // diff[WIDTH] is the borrow: set when the shifted remainder is below the divisor
            if (!diff[WIDTH]) begin
                nxt_hi = diff[WIDTH-1:0];
                nxt_lo = {acc_lo_q[WIDTH-2:0], 1'b1};
            end else begin
                nxt_hi = shifted[WIDTH-1:0];
                nxt_lo = {acc_lo_q[WIDTH-2:0], 1'b0};
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            opnd_q   <= '0;
        end else if (load) begin
            acc_hi_q <= '0;
            acc_lo_q <= is_div ? a_mag : b_mag;
            opnd_q   <= is_div ? b_mag : a_mag;
        end else if (step) begin
            acc_hi_q <= nxt_hi;
            acc_lo_q <= nxt_lo;
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; FSM, counter and sign handling live here.
// DIV/DIVU are decoded only when MULTDIV_DIV_EN is defined, otherwise they act as NOPs.
module mult_div_unit
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

`ifdef MULTDIV_DIV_EN
    localparam bit DivEn = 1'b1;
`else
    localparam bit DivEn = 1'b0;
`endif
    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    md_state_t          state_q, state_d;
    md_op_t             op_e;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               done_q, done_d;
    logic               res_neg_q, res_neg_d, rem_neg_q, rem_neg_d, is_div_q, is_div_d;
    logic               is_signed, a_neg, b_neg, load;
    logic [WIDTH-1:0]   a_mag, b_mag, core_hi, core_lo;
    logic [2*WIDTH-1:0] prod, prod_fix;

    md_iter_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk    (clk),
        .reset  (reset),
        .load   (load),
        .step   (busy),
        .is_div (is_div_d),
        .a_mag  (a_mag),
        .b_mag  (b_mag),
        .nxt_hi (core_hi),
        .nxt_lo (core_lo)
    );

    always_comb begin
        op_e      = md_op_t'(op);
        is_signed = (op_e == OpMult) || (op_e == OpDiv);
        a_neg     = is_signed & a[WIDTH-1];
        b_neg     = is_signed & b[WIDTH-1];
        a_mag     = a_neg ? -a : a;
        b_mag     = b_neg ? -b : b;
        prod      = {core_hi, core_lo};
        prod_fix  = res_neg_q ? -prod : prod;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        res_neg_d = res_neg_q;
        rem_neg_d = rem_neg_q;
        is_div_d  = is_div_q;
        load      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    case (op_e)
                        OpMult, OpMultu: begin
                            load      = 1'b1;
                            is_div_d  = 1'b0;
                            res_neg_d = a_neg ^ b_neg;
                            cnt_d     = '0;
                            state_d   = StCalc;
                        end
                        OpDiv, OpDivu: begin
                            if (DivEn) begin
                                if (b == '0) begin
                                    hi_d   = a;
                                    lo_d   = '1;
                                    done_d = 1'b1;
                                end else begin
                                    load      = 1'b1;
                                    is_div_d  = 1'b1;
                                    res_neg_d = a_neg ^ b_neg;
                                    rem_neg_d = a_neg;
                                    cnt_d     = '0;
                                    state_d   = StCalc;
                                end
                            end
                        end
                        OpMthi: begin
                            hi_d   = a;
                            done_d = 1'b1;
                        end
                        OpMtlo: begin
                            lo_d   = a;
                            done_d = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            StCalc: begin
                cnt_d = cnt_q + 1'b1;
                // Last step result is taken straight from the core and sign-corrected here
                if (cnt_q == LastCnt) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                    done_d  = 1'b1;
                    if (is_div_q) begin
                        lo_d = res_neg_q ? -core_lo : core_lo;
                        hi_d = rem_neg_q ? -core_hi : core_hi;
                    end else begin
                        {hi_d, lo_d} = prod_fix;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            res_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            is_div_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            res_neg_q <= res_neg_d;
            rem_neg_q <= rem_neg_d;
            is_div_q  <= is_div_d;
        end
    end

    assign busy = (state_q == StCalc);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed plus random bench for mult_div_unit against an arithmetic HI/LO model.
// Divide expectations follow MULTDIV_DIV_EN the same way the design does.
module tb_mult_div_unit;

`ifdef MULTDIV_DIV_EN
    localparam bit DivEn = 1'b1;
`else
    localparam bit DivEn = 1'b0;
`endif
    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
    localparam logic [2:0] OP_NOP   = 3'b110;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = OP_NOP;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;
    logic [31:0] mdl_hi = '0;
    logic [31:0] mdl_lo = '0;

    always #5 clk = ~clk;

    mult_div_unit #(
        .WIDTH (32)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Architectural effect of one issued op on the model HI/LO.
    task automatic model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         output bit is_long, output bit gives_done);
        longint      sx, sy, sq, sr;
        logic [63:0] ux, uy, r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'd0, x};
        uy = {32'd0, y};
        is_long = 1'b0;
        gives_done = 1'b1;
        case (o)
            OP_MULT: begin
                r = 64'(sx * sy);
                {mdl_hi, mdl_lo} = r;
                is_long = 1'b1;
            end
            OP_MULTU: begin
                r = ux * uy;
                {mdl_hi, mdl_lo} = r;
                is_long = 1'b1;
            end
            OP_DIV, OP_DIVU: begin
                if (!DivEn) begin
                    gives_done = 1'b0;
                end else if (y == 32'd0) begin
                    mdl_hi = x;
                    mdl_lo = 32'hFFFF_FFFF;
                end else begin
                    is_long = 1'b1;
                    if (o == OP_DIV) begin
                        sq = sx / sy;
                        sr = sx % sy;
                        mdl_lo = sq[31:0];
                        mdl_hi = sr[31:0];
                    end else begin
                        r = ux / uy;
                        mdl_lo = r[31:0];
                        r = ux % uy;
                        mdl_hi = r[31:0];
                    end
                end
            end
            OP_MTHI: mdl_hi = x;
            OP_MTLO: mdl_lo = x;
            default: gives_done = 1'b0;
        endcase
    endtask

    // Called at a negedge; drives the op there and returns at the negedge where done is expected.
    task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        bit          is_long, gives_done;
        int          busy_n, cyc;
        logic [31:0] old_hi, old_lo;
        old_hi = mdl_hi;
        old_lo = mdl_lo;
        model(o, x, y, is_long, gives_done);
        start = 1'b1;
        op = o;
        a = x;
        b = y;
        @(negedge clk);
        start = 1'b0;
        op = OP_NOP;
        a = $urandom;
        b = $urandom;
        busy_n = 0;
        cyc = 0;
        if (is_long) begin
            while (done !== 1'b1 && cyc < 80) begin
                if (busy === 1'b1) busy_n++;
                if (cyc == 5) begin
                    check("hold_hi", hi, old_hi);
                    check("hold_lo", lo, old_lo);
                end
                cyc++;
                @(negedge clk);
            end
            check("busy_len", busy_n, 32);
        end
        check("done", done, gives_done);
        check("busy_end", busy, 1'b0);
        check("hi", hi, mdl_hi);
        check("lo", lo, mdl_lo);
    endtask

    initial begin
        int          n, cyc;
        logic [2:0]  ro;
        logic [31:0] rx, ry;
        bit          l, g;

        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);

        do_op(OP_MULT, 32'hFFFF_FFFD, 32'd7);
        check("plan_mult_hi", hi, 32'hFFFF_FFFF);
        check("plan_mult_lo", lo, 32'hFFFF_FFEB);
        do_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);  // back-to-back issue in the done cycle
        check("plan_multu_hi", hi, 32'hFFFF_FFFE);
        check("plan_multu_lo", lo, 32'h0000_0001);
        do_op(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        do_op(OP_DIVU, 32'd100, 32'd7);
        if (DivEn) begin
            check("plan_divu_lo", lo, 32'd14);
            check("plan_divu_hi", hi, 32'd2);
        end
        do_op(OP_DIVU, 32'd100, 32'd0);
        do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        do_op(OP_MTHI, 32'h1234_5678, 32'd0);
        do_op(OP_MTLO, 32'h0000_0009, 32'd0);
        check("plan_mt_hi", hi, 32'h1234_5678);
        check("plan_mt_lo", lo, 32'h0000_0009);
        do_op(OP_NOP, 32'hDEAD_BEEF, 32'd1);
        do_op(3'b111, 32'hDEAD_BEEF, 32'd1);

        // start with MTLO mid-computation must be dropped, not queued
        model(OP_MULT, 32'hFFFF_1234, 32'h0000_5678, l, g);
        start = 1'b1; op = OP_MULT; a = 32'hFFFF_1234; b = 32'h0000_5678;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        start = 1'b1; op = OP_MTLO; a = 32'd5;
        @(negedge clk);
        start = 1'b0; op = OP_NOP;
        cyc = 0;
        while (done !== 1'b1 && cyc < 80) begin
            cyc++;
            @(negedge clk);
        end
        check("ign_done", done, 1'b1);
        check("ign_hi", hi, mdl_hi);
        check("ign_lo", lo, mdl_lo);
        @(negedge clk);
        check("ign_single_done", done, 1'b0);
        check("ign_not_queued", lo, mdl_lo);

        // reset in the middle of a multiply
        start = 1'b1; op = OP_MULT; a = 32'h0000_0100; b = 32'h0000_0200;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        mdl_hi = '0;
        mdl_lo = '0;
        check("rst_mid_hi", hi, 32'd0);
        check("rst_mid_lo", lo, 32'd0);
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_done", done, 1'b0);
        n = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) n++;
        end
        check("rst_mid_quiet", n, 0);

        for (int i = 0; i < 40; i++) begin
            ro = 3'($urandom_range(0, 7));
            rx = $urandom;
            case ($urandom_range(0, 3))
                0: ry = 32'd0;
                1: ry = 32'($urandom_range(1, 20));
                default: ry = $urandom;
            endcase
            do_op(ro, rx, ry);
        end

        @(negedge clk);
        check("final_done_low", done, 1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
